ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the EX stage and its IF/ID and ID/EX registers.
//  Detects load-use hazards that forwarding cannot resolve and flushes wrong-path work on a taken branch.
//  Holds the pipeline while a multi-cycle multiply/divide (MDU) op occupies the ALU.
//  Sits beside the forwarding unit; drives the PC, IF/ID and ID/EX write/flush controls.
// PARAMETERS
//  MDU_LAT  4   total EX cycles occupied by an MDU op (>=2, <=2**CNT_W)
//  CNT_W    3   width of the MDU occupancy down-counter
//  STAT_W   16  width of the saturating stall-cycle counter
// PORTS
//  clock          in   1      rising-edge clock
//  reset_n        in   1      synchronous, active-low reset
//  id_rs          in   5      rs field of the instruction in ID
//  id_rt          in   5      rt field of the instruction in ID
//  id_uses_rt     in   1      instruction in ID reads rt as a source
//  idex_memread   in   1      instruction in EX is a load (M-group memread bit)
//  idex_rt        in   5      destination register of that load
//  ex_branch_taken in  1      branch in EX resolved taken this cycle
//  ex_mdu_start   in   1      instruction in EX is a multi-cycle MDU op
//  pc_write       out  1      1 = PC may advance
//  ifid_write     out  1      1 = IF/ID may load
//  ifid_flush     out  1      1 = IF/ID loads a NOP
//  idex_bubble    out  1      1 = ID/EX control fields (WB/M/EX) load as zero
//  idex_hold      out  1      1 = ID/EX keeps its contents
//  mdu_busy       out  1      MDU op is occupying EX
//  mdu_done       out  1      1-cycle pulse in the final MDU cycle
//  stall_cycles   out  STAT_W count of cycles with pc_write=0, saturating
// BEHAVIOUR
//  State: RUN, MDU. Registers: state, cnt[CNT_W], stall_cycles. All other outputs are combinational from state and inputs.
//  Reset: when reset_n=0 at a clock edge: state<=RUN, cnt<=0, stall_cycles<=0.
//   While reset_n=0: pc_write=0, ifid_write=0, idex_bubble=1; all other 1-bit outputs are 0.
//  RUN defaults: pc_write=1, ifid_write=1; all other 1-bit outputs 0.
//  Priority in RUN, highest first:
//   1 ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. Any load-use or MDU condition is ignored.
//   2 ex_mdu_start: pc_write=0, ifid_write=0, idex_hold=1, mdu_busy=1; next state MDU, cnt<=MDU_LAT-1.
//   3 load-use, defined as idex_memread & idex_rt!=0 & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt)):
//     pc_write=0, ifid_write=0, idex_bubble=1. Stays in RUN; the stall lasts exactly 1 cycle because the load moves to MEM.
//  MDU state: mdu_busy=1. cnt decrements each cycle.
//   cnt>1: pc_write=0, ifid_write=0, idex_hold=1.
//   cnt==1 (final cycle): mdu_done=1, pc_write=1, ifid_write=1, idex_hold=0; next state RUN.
//   ex_branch_taken, ex_mdu_start and load-use are ignored in MDU.
//  Pipeline hold lasts exactly MDU_LAT-1 cycles from the start cycle. Release occurs in cycle MDU_LAT.
//  An MDU op immediately following another restarts from RUN on the next edge; there is no idle gap.
//  stall_cycles increments at each edge where pc_write=0 and reset_n=1, and holds at 2**STAT_W-1.
//  Reset mid-MDU aborts the op: next cycle is RUN with mdu_busy=0 and no mdu_done pulse.
//  idex_bubble and idex_hold are never both 1; ifid_flush implies pc_write=1.
// TESTING
//  T1 reset_n=0 for 2 cycles with ex_mdu_start=1 -> pc_write=0, idex_bubble=1, mdu_busy=0, stall_cycles=0;
//     release reset with inputs idle -> pc_write=1, ifid_write=1.
//  T2 idex_memread=1, idex_rt=5, id_rs=5 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1;
//     idex_rt=0 -> no stall; id_rt=5 with id_uses_rt=0 -> no stall.
//  T3 ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1, stall_cycles unchanged.
//  T4 MDU_LAT=4, ex_mdu_start held at cycles T..T+3 -> idex_hold=1 at T, T+1, T+2; mdu_done=1 and pc_write=1 at T+3;
//     stall_cycles +3; mdu_busy=0 at T+4.
//  T5 reset_n=0 at T+1 of an MDU op -> RUN at T+2, mdu_busy=0, no mdu_done pulse, cnt=0.
//  T6 STAT_W=4: 20 consecutive load-use stalls -> stall_cycles saturates at 15 and stays at 15.

Source files
------------

// File: rtl/ex_hazard_if.sv
// EX hazard controller bundle: ID/EX hazard inputs
// and pipeline write/flush/hold controls.
interface ex_hazard_if #(
  parameter int STAT_W = 16
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rt;
  logic              idex_memread;
  logic [4:0]        idex_rt;
  logic              ex_branch_taken;
  logic              ex_mdu_start;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              idex_hold;
  logic              mdu_busy;
  logic              mdu_done;
  logic [STAT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt,
    output idex_memread, idex_rt,
    output ex_branch_taken, ex_mdu_start,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_bubble, idex_hold,
    input  mdu_busy, mdu_done, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt,
    input  idex_memread, idex_rt,
    input  ex_branch_taken, ex_mdu_start,
    output pc_write, ifid_write, ifid_flush,
    output idex_bubble, idex_hold,
    output mdu_busy, mdu_done, stall_cycles
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencer: load-use stall, branch flush,
// multi-cycle MDU hold and saturating stall counter.
module ex_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 3,
  parameter int STAT_W  = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  ex_hazard_if.slave  hz
);

  typedef enum logic {
    RUN,
    MDU
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  logic load_use;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble;
  logic idex_hold;
  logic mdu_busy;
  logic mdu_done;

  // Load in EX whose target feeds the ID operands.
  always_comb begin
    load_use = hz.idex_memread
             & (hz.idex_rt != 5'd0)
             & ((hz.idex_rt == hz.id_rs)
             | (hz.id_uses_rt
             & (hz.idex_rt == hz.id_rt)));
  end

  // Next state, counter and pipeline controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hz.ex_mdu_start) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          mdu_busy   = 1'b1;
          state_d    = MDU;
          cnt_d      = CNT_W'(MDU_LAT - 1);
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MDU: begin
        mdu_busy = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q > CNT_W'(1)) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
        end else begin
          mdu_done = 1'b1;
          state_d  = RUN;
        end
      end
    endcase
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      idex_hold   = 1'b0;
      mdu_busy    = 1'b0;
      mdu_done    = 1'b0;
    end
  end

  // Stall-cycle statistic, saturating at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != '1)) begin
      stall_d = stall_q + STAT_W'(1);
    end
  end

  // State, occupancy counter and statistic registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.idex_hold    = idex_hold;
  assign hz.mdu_busy     = mdu_busy;
  assign hz.mdu_done     = mdu_done;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios plus
// random traffic checked against a cycle-level model.
module tb_ex_hazard_ctrl;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs = '0;
  logic [4:0] rt = '0;
  logic uses_rt = 1'b0;
  logic memrd = 1'b0;
  logic [4:0] ldrt = '0;
  logic br = 1'b0;
  logic start = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_hazard_if #(.STAT_W(16)) hz16 ();
  ex_hazard_if #(.STAT_W(4))  hz4 ();

  assign hz16.id_rs = rs;
  assign hz16.id_rt = rt;
  assign hz16.id_uses_rt = uses_rt;
  assign hz16.idex_memread = memrd;
  assign hz16.idex_rt = ldrt;
  assign hz16.ex_branch_taken = br;
  assign hz16.ex_mdu_start = start;
  assign hz4.id_rs = rs;
  assign hz4.id_rt = rt;
  assign hz4.id_uses_rt = uses_rt;
  assign hz4.idex_memread = memrd;
  assign hz4.idex_rt = ldrt;
  assign hz4.ex_branch_taken = br;
  assign hz4.ex_mdu_start = start;

  ex_hazard_ctrl #(
    .MDU_LAT(LAT), .CNT_W(3), .STAT_W(16)
  ) dut16 (
    .clock(clk), .reset_n(rst_n), .hz(hz16)
  );

  ex_hazard_ctrl #(
    .MDU_LAT(LAT), .CNT_W(3), .STAT_W(4)
  ) dut4 (
    .clock(clk), .reset_n(rst_n), .hz(hz4)
  );

  typedef struct packed {
    logic pc, ifw, fl, bub, hold, busy, done;
  } exp_t;

  // Model state: cycles elapsed in the current MDU op
  // (0 = no op in progress) and total stall cycles.
  int ph = 0;
  int total = 0;

  function automatic exp_t model(input int p);
    exp_t e;
    bit lu;
    e = '{pc: 1, ifw: 1, default: 0};
    lu = memrd && ldrt != 0 &&
         (ldrt == rs || (uses_rt && ldrt == rt));
    if (!rst_n) begin
      e = '{bub: 1, default: 0};
    end else if (p == 0) begin
      if (br) begin
        e.fl = 1;
        e.bub = 1;
      end else if (start) begin
        e.pc = 0;
        e.ifw = 0;
        e.hold = 1;
        e.busy = 1;
      end else if (lu) begin
        e.pc = 0;
        e.ifw = 0;
        e.bub = 1;
      end
    end else begin
      e.busy = 1;
      if (p == LAT - 1) e.done = 1;
      else begin
        e.pc = 0;
        e.ifw = 0;
        e.hold = 1;
      end
    end
    return e;
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Advance the model at each edge.
  always @(posedge clk) begin
    exp_t e;
    e = model(ph);
    if (!rst_n) begin
      ph = 0;
      total = 0;
    end else begin
      if (!e.pc) total++;
      if (ph == 0) ph = (start && !br) ? 1 : 0;
      else if (ph == LAT - 1) ph = 0;
      else ph++;
    end
    chk_en <= 1'b1;
  end

  // Compare both DUTs against the model every cycle.
  always @(negedge clk) begin
    exp_t e;
    int cap;
    if (chk_en) begin
      e = model(ph);
      cap = total > 15 ? 15 : total;
      chk("m_pc", int'(hz16.pc_write), int'(e.pc));
      chk("m_ifw", int'(hz16.ifid_write), int'(e.ifw));
      chk("m_flush", int'(hz16.ifid_flush), int'(e.fl));
      chk("m_bub", int'(hz16.idex_bubble), int'(e.bub));
      chk("m_hold", int'(hz16.idex_hold), int'(e.hold));
      chk("m_busy", int'(hz16.mdu_busy), int'(e.busy));
      chk("m_done", int'(hz16.mdu_done), int'(e.done));
      chk("m_pc4", int'(hz4.pc_write), int'(e.pc));
      chk("m_hold4", int'(hz4.idex_hold), int'(e.hold));
      chk("m_st16", int'(hz16.stall_cycles), total);
      chk("m_st4", int'(hz4.stall_cycles), cap);
    end
  end

  task automatic idle();
    rs = 0; rt = 0; uses_rt = 0;
    memrd = 0; ldrt = 0; br = 0; start = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #5;
  endtask

  initial begin
    int s;
    // T1: reset with MDU start asserted
    idle();
    start = 1;
    rst_n = 0;
    cyc();
    cyc();
    settle();
    chk("t1_pc", int'(hz16.pc_write), 0);
    chk("t1_bub", int'(hz16.idex_bubble), 1);
    chk("t1_busy", int'(hz16.mdu_busy), 0);
    chk("t1_st", int'(hz16.stall_cycles), 0);
    cyc();
    rst_n = 1;
    idle();
    settle();
    chk("t1_rel_pc", int'(hz16.pc_write), 1);
    chk("t1_rel_ifw", int'(hz16.ifid_write), 1);

    // T2: load-use on rs, one stall cycle
    cyc();
    memrd = 1; ldrt = 5; rs = 5;
    settle();
    chk("t2_pc", int'(hz16.pc_write), 0);
    chk("t2_ifw", int'(hz16.ifid_write), 0);
    chk("t2_bub", int'(hz16.idex_bubble), 1);
    cyc();
    idle();
    settle();
    chk("t2_after", int'(hz16.pc_write), 1);
    chk("t2_st", int'(hz16.stall_cycles), 1);
    cyc();
    memrd = 1; ldrt = 0; rs = 0;
    settle();
    chk("t2_r0", int'(hz16.pc_write), 1);
    cyc();
    memrd = 1; ldrt = 5; rs = 3; rt = 5;
    settle();
    chk("t2_nort", int'(hz16.pc_write), 1);
    cyc();
    uses_rt = 1;
    settle();
    chk("t2_rt", int'(hz16.pc_write), 0);

    // T3: branch beats load-use
    cyc();
    idle();
    memrd = 1; ldrt = 7; rs = 7; br = 1;
    settle();
    s = int'(hz16.stall_cycles);
    chk("t3_fl", int'(hz16.ifid_flush), 1);
    chk("t3_bub", int'(hz16.idex_bubble), 1);
    chk("t3_pc", int'(hz16.pc_write), 1);
    cyc();
    idle();
    settle();
    chk("t3_st", int'(hz16.stall_cycles), s);

    // T4: MDU op with start held for LAT cycles
    cyc();
    start = 1;
    settle();
    s = int'(hz16.stall_cycles);
    chk("t4_h0", int'(hz16.idex_hold), 1);
    chk("t4_pc0", int'(hz16.pc_write), 0);
    cyc();
    settle();
    chk("t4_h1", int'(hz16.idex_hold), 1);
    cyc();
    settle();
    chk("t4_h2", int'(hz16.idex_hold), 1);
    chk("t4_d2", int'(hz16.mdu_done), 0);
    cyc();
    settle();
    chk("t4_d3", int'(hz16.mdu_done), 1);
    chk("t4_pc3", int'(hz16.pc_write), 1);
    chk("t4_h3", int'(hz16.idex_hold), 0);
    cyc();
    start = 0;
    settle();
    chk("t4_busy4", int'(hz16.mdu_busy), 0);
    chk("t4_st", int'(hz16.stall_cycles), s + 3);

    // T5: reset during an MDU op aborts it
    cyc();
    start = 1;
    cyc();
    start = 0;
    rst_n = 0;
    settle();
    chk("t5_rbusy", int'(hz16.mdu_busy), 0);
    cyc();
    rst_n = 1;
    settle();
    chk("t5_busy", int'(hz16.mdu_busy), 0);
    chk("t5_done", int'(hz16.mdu_done), 0);
    chk("t5_pc", int'(hz16.pc_write), 1);
    chk("t5_st", int'(hz16.stall_cycles), 0);
    cyc();
    start = 1;
    cyc();
    start = 0;
    settle();
    chk("t5_new_h", int'(hz16.idex_hold), 1);
    cyc();
    cyc();
    settle();
    chk("t5_new_d", int'(hz16.mdu_done), 1);

    // T6: 20 stall cycles saturate the 4-bit counter
    cyc();
    rst_n = 0;
    idle();
    cyc();
    rst_n = 1;
    memrd = 1; ldrt = 9; rs = 9;
    for (int i = 0; i < 20; i++) cyc();
    settle();
    chk("t6_st4", int'(hz4.stall_cycles), 15);
    chk("t6_st16", int'(hz16.stall_cycles), 20);
    for (int i = 0; i < 3; i++) cyc();
    settle();
    chk("t6_hold15", int'(hz4.stall_cycles), 15);

    // Random traffic
    cyc();
    idle();
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n = ($urandom_range(0, 99) >= 2);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      ldrt = 5'($urandom_range(0, 7));
      uses_rt = 1'($urandom_range(0, 1));
      memrd = ($urandom_range(0, 99) < 40);
      br = ($urandom_range(0, 99) < 15);
      start = ($urandom_range(0, 99) < 10);
    end
    cyc();
    idle();
    cyc();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
